// File: rtl/ce_delay_pipe.sv
// Stallable delay line of DEPTH registered stages with per-stage valid bits,
// an incremental occupancy count and a clamped combinational output tap.
module ce_delay_pipe #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter bit ZERO_INV = 1'b1,
  localparam int TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Ce,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Din,
  input  logic             Vin,
  input  logic [TW-1:0]    Tap,
  output logic [WIDTH-1:0] Dout,
  output logic             Vout,
  output logic [OW-1:0]    Occ
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [OW-1:0]    occ_q;

  logic [TW-1:0]    tap_eff;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value; blocking would collapse the chain.
  // NOTE: the data registers are cleared on reset and flush because an
  // invalid stage may still be shown raw when ZERO_INV is 0.
  always_ff @(posedge CLK) begin
    if (RST || Flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else if (Ce) begin
      data_q[0]  <= Din;
      valid_q[0] <= Vin;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      // One word enters and one leaves per advance, so the count stays in range.
      occ_q <= occ_q + OW'(Vin) - OW'(valid_q[DEPTH-1]);
    end
  end

  // A power-of-two depth fills the tap range exactly, so no clamp is needed.
  generate
    if (DEPTH == (1 << TW)) begin : g_tap_full
      assign tap_eff = Tap;
    end else begin : g_tap_clamp
      localparam logic [TW-1:0] LAST = TW'(DEPTH - 1);
      assign tap_eff = (Tap > LAST) ? LAST : Tap;
    end
  endgenerate

  // NOTE: defaults come first so every path assigns the outputs and no latch
  // is inferred from the search loop.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (TW'(k) == tap_eff) begin
        sel_data  = data_q[k];
        sel_valid = valid_q[k];
      end
    end
  end

  assign Vout = sel_valid;
  assign Dout = (ZERO_INV && !sel_valid) ? '0 : sel_data;
  assign Occ  = occ_q;

endmodule

// File: tb/tb_ce_delay_pipe.sv
// Bench for ce_delay_pipe: three instances (4-deep zeroing, 4-deep raw, 5-deep
// clamping) compared against a queue-based model of the delay line.
module tb_ce_delay_pipe;

  typedef struct {
    bit         v;
    logic [3:0] d;
  } ent_t;

  logic       CLK = 1'b0;
  logic       RST, Ce, Flush, Vin;
  logic [3:0] Din;
  logic [1:0] tap4;
  logic [2:0] tap5;

  logic [3:0] dout_a, dout_z, dout_c;
  logic       vout_a, vout_z, vout_c;
  logic [2:0] occ_a, occ_z, occ_c;

  int vectors     = 0;
  int miscompares = 0;

  ent_t m4[$];
  ent_t m5[$];

  always #5 CLK = ~CLK;

  ce_delay_pipe #(.WIDTH(4), .DEPTH(4), .ZERO_INV(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .Ce(Ce), .Flush(Flush), .Din(Din), .Vin(Vin),
    .Tap(tap4), .Dout(dout_a), .Vout(vout_a), .Occ(occ_a)
  );

  ce_delay_pipe #(.WIDTH(4), .DEPTH(4), .ZERO_INV(1'b0)) u_z (
    .CLK(CLK), .RST(RST), .Ce(Ce), .Flush(Flush), .Din(Din), .Vin(Vin),
    .Tap(tap4), .Dout(dout_z), .Vout(vout_z), .Occ(occ_z)
  );

  ce_delay_pipe #(.WIDTH(4), .DEPTH(5), .ZERO_INV(1'b1)) u_c (
    .CLK(CLK), .RST(RST), .Ce(Ce), .Flush(Flush), .Din(Din), .Vin(Vin),
    .Tap(tap5), .Dout(dout_c), .Vout(vout_c), .Occ(occ_c)
  );

  // Model: each pipeline is a queue, newest word at the front.
  task automatic model_edge();
    ent_t e;
    if (RST || Flush) begin
      m4 = {};
      m5 = {};
      e.v = 1'b0;
      e.d = 4'h0;
      for (int i = 0; i < 4; i++) m4.push_back(e);
      for (int i = 0; i < 5; i++) m5.push_back(e);
    end else if (Ce) begin
      e.v = Vin;
      e.d = Din;
      m4.push_front(e);
      m5.push_front(e);
      void'(m4.pop_back());
      void'(m5.pop_back());
    end
  endtask

  function automatic ent_t pick(int depth, int tap);
    int t;
    t = (tap > depth - 1) ? depth - 1 : tap;
    return (depth == 4) ? m4[t] : m5[t];
  endfunction

  function automatic logic [3:0] exp_dout(int depth, bit zinv, int tap);
    ent_t e;
    e = pick(depth, tap);
    return (zinv && !e.v) ? 4'h0 : e.d;
  endfunction

  function automatic int exp_occ(int depth);
    int n = 0;
    for (int i = 0; i < depth; i++) begin
      if (depth == 4 && m4[i].v) n++;
      if (depth == 5 && m5[i].v) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; Ce = 1'b0; Flush = 1'b0; Vin = 1'b0; Din = 4'h0;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      Ce = 1'b1; Vin = 1'b1; Din = 4'($urandom_range(1, 15));
      step();
    end
    vectors++;
    if (occ_a !== 3'd4) begin
      miscompares++;
      $display("FAIL reset_fill_occ: got %0d want 4", occ_a);
    end
    RST = 1'b1; Ce = 1'b1; Vin = 1'b1; Din = 4'hA;
    step();
    RST = 1'b0; Ce = 1'b0; Vin = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap4 = 2'(t);
      #1;
      vectors++;
      if (dout_a !== 4'h0 || vout_a !== 1'b0 || dout_z !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_tap%0d: dout=%h vout=%b dout_raw=%h want 0/0/0", t, dout_a, vout_a, dout_z);
      end
    end
    vectors++;
    if (occ_a !== 3'd0 || occ_z !== 3'd0 || occ_c !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_occ: got %0d/%0d/%0d want 0", occ_a, occ_z, occ_c);
    end
  endtask

  task automatic test_stream();
    logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] want;
    do_reset();
    tap4 = 2'd3; tap5 = 3'd7;
    for (int i = 0; i < 4; i++) begin
      Ce = 1'b1; Vin = 1'b1; Din = vals[i];
      step();
      vectors++;
      if (int'(occ_a) !== i + 1) begin
        miscompares++;
        $display("FAIL stream_fill_occ%0d: got %0d want %0d", i, occ_a, i + 1);
      end
      vectors++;
      if (dout_c !== exp_dout(5, 1'b1, 7) || int'(occ_c) !== exp_occ(5)) begin
        miscompares++;
        $display("FAIL stream_clamp%0d: dout=%h occ=%0d want %h/%0d", i, dout_c, occ_c, exp_dout(5, 1'b1, 7), exp_occ(5));
      end
      if (i == 2) begin
        tap4 = 2'd0;
        #1;
        vectors++;
        if (dout_a !== 4'h4 || vout_a !== 1'b1) begin
          miscompares++;
          $display("FAIL tap_switch: dout=%h vout=%b want 4/1", dout_a, vout_a);
        end
        tap4 = 2'd3;
        #1;
      end
    end
    vectors++;
    if (dout_a !== 4'h1 || vout_a !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_first_out: dout=%h vout=%b want 1/1", dout_a, vout_a);
    end
    for (int i = 0; i < 4; i++) begin
      Din = 4'h0; Vin = 1'b0;
      step();
      want = (i < 3) ? vals[i+1] : 4'h0;
      vectors++;
      if (dout_a !== want || int'(occ_a) !== 3 - i) begin
        miscompares++;
        $display("FAIL stream_drain%0d: dout=%h occ=%0d want %h/%0d", i, dout_a, occ_a, want, 3 - i);
      end
      vectors++;
      if (dout_c !== exp_dout(5, 1'b1, 7) || int'(occ_c) !== exp_occ(5)) begin
        miscompares++;
        $display("FAIL stream_clamp_drain%0d: dout=%h occ=%0d want %h/%0d", i, dout_c, occ_c, exp_dout(5, 1'b1, 7), exp_occ(5));
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    do_reset();
    tap4 = 2'd3;
    for (int c = 0; c < 8; c++) begin
      Ce = (c % 2) == 1; Vin = 1'b1; Din = vals[c/2];
      step();
      vectors++;
      if (dout_a !== exp_dout(4, 1'b1, 3) || int'(occ_a) !== exp_occ(4)) begin
        miscompares++;
        $display("FAIL enable_c%0d: dout=%h occ=%0d want %h/%0d", c, dout_a, occ_a, exp_dout(4, 1'b1, 3), exp_occ(4));
      end
    end
    vectors++;
    if (dout_a !== 4'h1 || occ_a !== 3'd4) begin
      miscompares++;
      $display("FAIL enable_latency: dout=%h occ=%0d want 1/4", dout_a, occ_a);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      Ce = 1'b1; Vin = 1'b1; Din = 4'(i + 9);
      step();
    end
    Flush = 1'b1; Ce = 1'b1; Vin = 1'b1; Din = 4'h7;
    step();
    Flush = 1'b0;
    vectors++;
    if (occ_a !== 3'd0 || occ_c !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_occ: got %0d/%0d want 0", occ_a, occ_c);
    end
    for (int t = 0; t < 4; t++) begin
      tap4 = 2'(t);
      #1;
      vectors++;
      if (vout_a !== 1'b0 || dout_z !== 4'h0) begin
        miscompares++;
        $display("FAIL flush_tap%0d: vout=%b dout_raw=%h want 0/0", t, vout_a, dout_z);
      end
    end
    Ce = 1'b1; Vin = 1'b1; Din = 4'h5;
    step();
    tap4 = 2'd0;
    #1;
    vectors++;
    if (occ_a !== 3'd1 || dout_a !== 4'h5 || vout_a !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_resume: occ=%0d dout=%h vout=%b want 1/5/1", occ_a, dout_a, vout_a);
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    Ce = 1'b1; Din = 4'hF;
    for (int i = 0; i < 8; i++) begin
      Vin = (i % 2) == 0;
      step();
      if (i >= 3) begin
        vectors++;
        if (occ_a !== 3'd2) begin
          miscompares++;
          $display("FAIL bubble_occ%0d: got %0d want 2", i, occ_a);
        end
      end
    end
    Ce = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap4 = 2'(t);
      #1;
      vectors++;
      if ((t % 2) == 0) begin
        if (dout_a !== 4'h0 || vout_a !== 1'b0 || dout_z !== 4'hF) begin
          miscompares++;
          $display("FAIL bubble_tap%0d: dout=%h vout=%b dout_raw=%h want 0/0/f", t, dout_a, vout_a, dout_z);
        end
      end else begin
        if (dout_a !== 4'hF || vout_a !== 1'b1 || dout_z !== 4'hF) begin
          miscompares++;
          $display("FAIL bubble_tap%0d: dout=%h vout=%b dout_raw=%h want f/1/f", t, dout_a, vout_a, dout_z);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      RST   = $urandom_range(0, 99) < 3;
      Flush = $urandom_range(0, 99) < 5;
      Ce    = $urandom_range(0, 99) < 70;
      Vin   = 1'($urandom);
      Din   = 4'($urandom);
      tap4  = 2'($urandom);
      tap5  = 3'($urandom);
      step();
      vectors++;
      if (dout_a !== exp_dout(4, 1'b1, int'(tap4)) || vout_a !== pick(4, int'(tap4)).v
          || int'(occ_a) !== exp_occ(4)) begin
        miscompares++;
        $display("FAIL rand_a n=%0d: dout=%h vout=%b occ=%0d want %h/%b/%0d", n, dout_a, vout_a, occ_a,
                 exp_dout(4, 1'b1, int'(tap4)), pick(4, int'(tap4)).v, exp_occ(4));
      end
      vectors++;
      if (dout_z !== exp_dout(4, 1'b0, int'(tap4)) || vout_z !== pick(4, int'(tap4)).v
          || int'(occ_z) !== exp_occ(4)) begin
        miscompares++;
        $display("FAIL rand_raw n=%0d: dout=%h vout=%b occ=%0d want %h/%b/%0d", n, dout_z, vout_z, occ_z,
                 exp_dout(4, 1'b0, int'(tap4)), pick(4, int'(tap4)).v, exp_occ(4));
      end
      vectors++;
      if (dout_c !== exp_dout(5, 1'b1, int'(tap5)) || vout_c !== pick(5, int'(tap5)).v
          || int'(occ_c) !== exp_occ(5)) begin
        miscompares++;
        $display("FAIL rand_d5 n=%0d tap=%0d: dout=%h vout=%b occ=%0d want %h/%b/%0d", n, tap5, dout_c, vout_c,
                 occ_c, exp_dout(5, 1'b1, int'(tap5)), pick(5, int'(tap5)).v, exp_occ(5));
      end
    end
  endtask

  initial begin
    RST = 1'b1; Ce = 1'b0; Flush = 1'b0; Vin = 1'b0; Din = 4'h0;
    tap4 = 2'd3; tap5 = 3'd4;
    test_reset();
    test_stream();
    test_enable();
    test_flush();
    test_bubbles();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
